hog_cell_hist_ctrl: RTL and testbench

//  Accumulates the per-pixel orientation votes (bottom/top bin + split weights from the bin-choice

---
 rtl/hog_cell_hist_ctrl_if.sv | 26 ++
 rtl/hog_cell_hist_ctrl.sv | 170 +++++++++++++++++
 tb/tb_hog_cell_hist_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/hog_cell_hist_ctrl_if.sv
// rtl/hog_cell_hist_ctrl_if.sv - vote input and cell histogram output bundle
interface hog_cell_hist_ctrl_if #(
    parameter int W_W   = 8,
    parameter int ACC_W = 16
);
    logic               frameStart;
    logic               de;
    logic [3:0]         bottomBin;
    logic [3:0]         topBin;
    logic [W_W-1:0]     bottomW;
    logic [W_W-1:0]     topW;
    logic               histValid;
    logic [6:0]         histCellX;
    logic [5:0]         histCellY;
    logic [9*ACC_W-1:0] histData;

    modport master (
        output frameStart, de, bottomBin, topBin, bottomW, topW,
        input  histValid, histCellX, histCellY, histData
    );

    modport slave (
        input  frameStart, de, bottomBin, topBin, bottomW, topW,
        output histValid, histCellX, histCellY, histData
    );
endinterface

// File: rtl/hog_cell_hist_ctrl.sv
// rtl/hog_cell_hist_ctrl.sv - 9-bin HOG cell histogram accumulator over 8x8 cells
module hog_cell_hist_ctrl #(
    parameter int CELLS_X = 80,
    parameter int CELLS_Y = 60,
    parameter int W_W     = 8,
    parameter int ACC_W   = 16
) (
    input  logic                 pclk,
    input  logic                 reset,
    hog_cell_hist_ctrl_if.slave  bus
);
    // Partial sums must hold 8 pixels with both weights landing on one bin.
    localparam int PS_W = W_W + 4;
    localparam int CX_W = (CELLS_X > 1) ? $clog2(CELLS_X) : 1;
    localparam int CY_W = (CELLS_Y > 1) ? $clog2(CELLS_Y) : 1;
    localparam int HW   = 9 * ACC_W;

    typedef enum logic {WAIT_FRAME, ACTIVE} state_t;

    state_t            state, state_nx;
    logic              de_d;
    logic [2:0]        pix_x;
    logic [2:0]        line_in_cell;
    logic [CX_W-1:0]   cell_x;
    logic [CY_W-1:0]   cell_y;
    logic              over;

    logic [PS_W-1:0]   part    [9];
    logic [PS_W-1:0]   part_nx [9];

    logic [HW-1:0]     ram [CELLS_X];
    logic [HW-1:0]     rd_data;
    logic [HW-1:0]     new_val;

    logic              upd_pend;
    logic [CX_W-1:0]   upd_cx;
    logic [CY_W-1:0]   upd_cy;
    logic [2:0]        upd_line;

    logic              vote;
    logic              cell_done;
    logic              line_end;
    logic              frame_done;

    // Event decode and next-state selection
    always_comb begin
        vote       = (state == ACTIVE) && bus.de && !over && !bus.frameStart;
        cell_done  = vote && (pix_x == 3'd7);
        line_end   = (state == ACTIVE) && de_d && !bus.de && !bus.frameStart;
        frame_done = line_end && (line_in_cell == 3'd7) &&
                     (cell_y == CY_W'(CELLS_Y - 1));
        state_nx   = state;
        if (bus.frameStart) begin
            state_nx = ACTIVE;
        end else if (frame_done) begin
            state_nx = WAIT_FRAME;
        end
    end

    // State register
    always_ff @(posedge pclk) begin
        if (reset) begin
            state <= WAIT_FRAME;
        end else begin
            state <= state_nx;
        end
    end

    // Next partial sums: cleared on update, line end or frame start, then add this pixel's votes
    always_comb begin
        for (int k = 0; k < 9; k++) begin
            part_nx[k] = (upd_pend || line_end || bus.frameStart) ? '0 : part[k];
            if (vote && bus.bottomBin == 4'(k)) begin
                part_nx[k] = part_nx[k] + PS_W'(bus.bottomW);
            end
            if (vote && bus.topBin == 4'(k)) begin
                part_nx[k] = part_nx[k] + PS_W'(bus.topW);
            end
        end
    end

    // Saturating merge of the finished cell partials into the row-buffer entry
    always_comb begin
        logic [ACC_W-1:0] old_v;
        logic [ACC_W:0]   sum;
        new_val = '0;
        for (int k = 0; k < 9; k++) begin
            old_v = (upd_line == 3'd0) ? '0 : rd_data[k*ACC_W +: ACC_W];
            sum   = {1'b0, old_v} + (ACC_W + 1)'(part[k]);
            new_val[k*ACC_W +: ACC_W] = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
        end
    end

    // Pixel/cell/line counters, partial sums and the pending-update record
    always_ff @(posedge pclk) begin
        if (reset) begin
            de_d         <= 1'b0;
            pix_x        <= '0;
            cell_x       <= '0;
            cell_y       <= '0;
            line_in_cell <= '0;
            over         <= 1'b0;
            upd_pend     <= 1'b0;
            upd_cx       <= '0;
            upd_cy       <= '0;
            upd_line     <= '0;
            for (int k = 0; k < 9; k++) part[k] <= '0;
        end else begin
            de_d <= bus.de;
            for (int k = 0; k < 9; k++) part[k] <= part_nx[k];
            upd_pend <= cell_done;
            if (cell_done) begin
                upd_cx   <= cell_x;
                upd_cy   <= cell_y;
                upd_line <= line_in_cell;
            end
            if (bus.frameStart) begin
                pix_x        <= '0;
                cell_x       <= '0;
                cell_y       <= '0;
                line_in_cell <= '0;
                over         <= 1'b0;
            end else if (line_end) begin
                pix_x        <= '0;
                cell_x       <= '0;
                over         <= 1'b0;
                line_in_cell <= line_in_cell + 3'd1;
                if (line_in_cell == 3'd7) begin
                    cell_y <= frame_done ? '0 : cell_y + CY_W'(1);
                end
            end else if (vote) begin
                pix_x <= pix_x + 3'd1;
                if (pix_x == 3'd7) begin
                    if (cell_x == CX_W'(CELLS_X - 1)) begin
                        over <= 1'b1;
                    end else begin
                        cell_x <= cell_x + CX_W'(1);
                    end
                end
            end
        end
    end

    // Row buffer: read at the first pixel of a cell, write back after its eighth pixel
    always_ff @(posedge pclk) begin
        if (vote && pix_x == 3'd0) begin
            rd_data <= ram[cell_x];
        end
        if (upd_pend && upd_line != 3'd7) begin
            ram[upd_cx] <= new_val;
        end
    end

    // Finished-cell output register, loaded on the eighth line of a cell row
    always_ff @(posedge pclk) begin
        if (reset) begin
            bus.histValid <= 1'b0;
            bus.histCellX <= '0;
            bus.histCellY <= '0;
            bus.histData  <= '0;
        end else begin
            bus.histValid <= upd_pend && (upd_line == 3'd7) && !bus.frameStart;
            if (upd_pend && upd_line == 3'd7 && !bus.frameStart) begin
                bus.histData  <= new_val;
                bus.histCellX <= 7'(upd_cx);
                bus.histCellY <= 6'(upd_cy);
            end
        end
    end
endmodule

// File: tb/tb_hog_cell_hist_ctrl.sv
// tb/tb_hog_cell_hist_ctrl.sv - directed self-checking bench for hog_cell_hist_ctrl
module tb_hog_cell_hist_ctrl;
    localparam int CX = 4;
    localparam int CY = 3;

    logic       pclk  = 1'b0;
    logic       reset = 1'b1;
    logic       fs    = 1'b0;
    logic       de    = 1'b0;
    logic [3:0] bb    = '0;
    logic [3:0] tb    = '0;
    logic [7:0] bw    = '0;
    logic [7:0] tw    = '0;

    always #5 pclk = ~pclk;

    hog_cell_hist_ctrl_if #(.W_W(8), .ACC_W(16)) ia ();
    hog_cell_hist_ctrl_if #(.W_W(8), .ACC_W(14)) ib ();

    assign ia.frameStart = fs;  assign ib.frameStart = fs;
    assign ia.de         = de;  assign ib.de         = de;
    assign ia.bottomBin  = bb;  assign ib.bottomBin  = bb;
    assign ia.topBin     = tb;  assign ib.topBin     = tb;
    assign ia.bottomW    = bw;  assign ib.bottomW    = bw;
    assign ia.topW       = tw;  assign ib.topW       = tw;

    hog_cell_hist_ctrl #(.CELLS_X(CX), .CELLS_Y(CY), .W_W(8), .ACC_W(16)) dut_a (
        .pclk  (pclk),
        .reset (reset),
        .bus   (ia)
    );

    hog_cell_hist_ctrl #(.CELLS_X(CX), .CELLS_Y(CY), .W_W(8), .ACC_W(14)) dut_b (
        .pclk  (pclk),
        .reset (reset),
        .bus   (ib)
    );

    int cyc = 0;
    always @(posedge pclk) cyc++;

    int             qx[$];
    int             qy[$];
    int             qc[$];
    logic [143:0]   qd[$];
    logic [125:0]   qe[$];

    always @(negedge pclk) begin
        if (ia.histValid) begin
            qx.push_back(int'(ia.histCellX));
            qy.push_back(int'(ia.histCellY));
            qc.push_back(cyc);
            qd.push_back(ia.histData);
        end
        if (ib.histValid) qe.push_back(ib.histData);
    end

    int total = 0;
    int bad   = 0;
    int last_cyc = 0;

    task automatic check(input string tag, input longint got, input longint want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    function automatic int bin_a(input int i, input int k);
        logic [143:0] d;
        d = qd[i];
        return int'(d[k*16 +: 16]);
    endfunction

    function automatic int bin_b(input int i, input int k);
        logic [125:0] d;
        d = qe[i];
        return int'(d[k*14 +: 14]);
    endfunction

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic clr();
        qx.delete(); qy.delete(); qc.delete(); qd.delete(); qe.delete();
    endtask

    task automatic frame_start();
        fs = 1'b1; de = 1'b0;
        tick();
        fs = 1'b0;
        tick();
    endtask

    task automatic send_line(input int n, input int nx, input logic [3:0] b0, input logic [3:0] b1,
                             input logic [7:0] w0, input logic [7:0] w1);
        for (int i = 0; i < n; i++) begin
            de = 1'b1; bb = b0; tb = b1; bw = w0; tw = w1;
            if (i == n - 1) last_cyc = cyc;
            tick();
        end
        for (int i = 0; i < nx; i++) begin
            de = 1'b1; bb = 4'd4; tb = 4'd4; bw = 8'd50; tw = 8'd50;
            tick();
        end
        de = 1'b0; bb = '0; tb = '0; bw = '0; tw = '0;
        repeat (3) tick();
    endtask

    task automatic std_lines(input int n);
        for (int l = 0; l < n; l++) send_line(8 * CX, 0, 4'd2, 4'd3, 8'd10, 8'd5);
    endtask

    initial begin
        repeat (3) tick();
        check("rst_valid", ia.histValid, 0);
        check("rst_data", (ia.histData == '0) ? 0 : 1, 0);
        check("rst_cellx", ia.histCellX, 0);
        check("rst_celly", ia.histCellY, 0);
        reset = 1'b0;
        tick();

        // Row 0: bins 2/3, weights 10/5
        clr();
        frame_start();
        std_lines(8);
        check("t1_count", qx.size(), CX);
        for (int i = 0; i < CX; i++) begin
            check("t1_cellx", qx[i], i);
            check("t1_celly", qy[i], 0);
            check("t1_bin2", bin_a(i, 2), 640);
            check("t1_bin3", bin_a(i, 3), 320);
            check("t1_bin0", bin_a(i, 0), 0);
            check("t1_bin8", bin_a(i, 8), 0);
        end
        check("t1_latency", qc[CX-1] - last_cyc, 2);

        // Row 1: both votes on bin 8 at 255, saturation on the narrow instance
        clr();
        for (int l = 0; l < 8; l++) send_line(8 * CX, 0, 4'd8, 4'd8, 8'd255, 8'd255);
        check("t2_count", qx.size(), CX);
        check("t2_celly", qy[0], 1);
        check("t2_bin8_w16", bin_a(0, 8), 32640);
        check("t2_bin8_w14", bin_b(0, 8), 16383);
        check("t2_bin2_stale", bin_a(1, 2), 0);
        check("t2_last_w14", bin_b(CX-1, 8), 16383);

        // Row 2: bottom index 9 dropped, only bin 0 counts; stale bin 8 must vanish
        clr();
        for (int l = 0; l < 8; l++) send_line(8 * CX, 0, 4'd9, 4'd0, 8'd7, 8'd7);
        check("t4_count", qx.size(), CX);
        check("t4_celly", qy[2], 2);
        check("t4_bin0", bin_a(2, 0), 448);
        check("t4_bin8", bin_a(2, 8), 0);
        check("t4_bin8_w14", bin_b(3, 8), 0);

        // Frame complete: further lines ignored
        clr();
        std_lines(8);
        check("t6_idle_count", qx.size(), 0);

        // Overlong line and a short line ending inside the last cell
        clr();
        frame_start();
        send_line(8 * CX, 2, 4'd2, 4'd3, 8'd10, 8'd5);
        std_lines(4);
        send_line(8 * CX - 4, 0, 4'd2, 4'd3, 8'd10, 8'd5);
        std_lines(2);
        check("t3_count", qx.size(), CX);
        check("t3_c2_bin2", bin_a(2, 2), 640);
        check("t3_c3_bin2", bin_a(3, 2), 560);
        check("t3_c3_bin3", bin_a(3, 3), 280);
        check("t3_c0_bin4", bin_a(0, 4), 0);

        // frameStart after 3 lines restarts the cell row
        clr();
        frame_start();
        for (int l = 0; l < 3; l++) send_line(8 * CX, 0, 4'd1, 4'd1, 8'd9, 8'd9);
        frame_start();
        std_lines(8);
        check("t5_count", qx.size(), CX);
        check("t5_celly", qy[0], 0);
        check("t5_bin2", bin_a(0, 2), 640);
        check("t5_bin1", bin_a(0, 1), 0);

        // Reset while cell 0 of line 7 is pending
        clr();
        std_lines(7);
        for (int i = 0; i < 8; i++) begin
            de = 1'b1; bb = 4'd2; tb = 4'd3; bw = 8'd10; tw = 8'd5;
            tick();
        end
        reset = 1'b1; de = 1'b0;
        tick();
        check("t5r_valid", ia.histValid, 0);
        check("t5r_data", (ia.histData == '0) ? 0 : 1, 0);
        reset = 1'b0;
        repeat (4) tick();
        std_lines(8);
        check("t5r_count", qx.size(), 0);
        frame_start();
        std_lines(8);
        check("t5r_after_count", qx.size(), CX);
        check("t5r_after_bin2", bin_a(0, 2), 640);

        // Full frame
        clr();
        frame_start();
        std_lines(8 * CY);
        check("t6_count", qx.size(), CX * CY);
        check("t6_last_x", qx[CX*CY-1], CX - 1);
        check("t6_last_y", qy[CX*CY-1], CY - 1);
        check("t6_last_bin3", bin_a(CX*CY-1, 3), 320);
        clr();
        std_lines(8);
        check("t6_after_count", qx.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
